// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with an internal 4:1 data mux and a valid/ready output.
// Each grant is capped at MAX_HOLD accepted words, and every grant returns through IDLE.
module mux_rr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] data_in,
   output logic [3:0]         gnt,
   output logic [1:0]         sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [WIDTH-1:0]  slice [4];
   logic              win_found;
   logic [1:0]        winner;
   logic [1:0]        scan_idx;
   logic              xfer;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slice
         assign slice[gi] = data_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Rotating priority: the first asserted request at or after ptr wins.
   always_comb begin
      win_found = 1'b0;
      winner    = 2'd0;
      scan_idx  = 2'd0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr_q + 2'(k);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            winner    = scan_idx;
         end
      end
   end

   assign out_valid = (state_q == GRANT) && req[sel_q];
   assign out_data  = out_valid ? slice[sel_q] : '0;
   assign xfer      = out_valid && out_ready;
   assign gnt       = gnt_q;
   assign sel       = sel_q;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = GRANT;
               sel_d      = winner;
               gnt_d      = 4'b0001 << winner;
               hold_cnt_d = '0;
            end
         end
         GRANT: begin
            // A dropped request releases even while stalled; no word moves that cycle.
            if (!req[sel_q] || (xfer && hold_cnt_q == HOLD_LAST)) begin
               state_d    = IDLE;
               gnt_d      = 4'b0000;
               ptr_d      = sel_q + 2'd1;
               hold_cnt_d = '0;
            end else if (xfer) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= 4'b0000;
         sel_q      <= 2'd0;
         ptr_q      <= 2'd0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

endmodule
